// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter shared by the fetch stage and the host loader.
// It boot-loads the program while fetch is stalled, then redirects fetch to
// address 0. In run mode it slots host patch writes into fetch-stall cycles and
// forces a one-cycle fetch stall when a write has been refused for too long.
module imem_load_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    input  logic              fetch_stall_in,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              stall_fetch,
    output logic              redirect,
    output logic [31:0]       redirect_addr,
    output logic              running,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {BOOT, FLUSH, RUN} state_t;

    localparam logic [3:0]    WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              grant;

    // State, refusal counter and boot word counter; reset returns to BOOT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus all port-facing controls, decoded from state and live inputs.
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        cnt_d       = cnt_q;
        grant       = 1'b0;
        host_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = fetch_addr;
        stall_fetch = 1'b0;
        redirect    = 1'b0;
        running     = 1'b0;
        case (state_q)
            BOOT: begin
                host_ready  = 1'b1;
                stall_fetch = 1'b1;
                mem_addr    = host_addr;
                mem_we      = host_valid;
                if (host_valid) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (host_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // PC loads the redirect target on the first unstalled cycle.
                redirect = 1'b1;
                if (!fetch_stall_in) state_d = RUN;
            end
            RUN: begin
                running    = 1'b1;
                grant      = fetch_stall_in | (wait_q == WAIT_MAX);
                host_ready = grant;
                if (host_valid && grant) begin
                    mem_we      = 1'b1;
                    mem_addr    = host_addr;
                    // Only a forced grant steals a cycle from fetch.
                    stall_fetch = !fetch_stall_in;
                end else if (host_valid) begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign mem_din       = host_data;
    assign redirect_addr = '0;
    assign load_count    = cnt_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench: each step drives inputs, queues the expected outputs and
// compares them against the DUT on the following falling edge.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_valid = 1'b0, host_ready, host_last = 1'b0;
    logic [9:0]  host_addr = '0, fetch_addr = '0, mem_addr;
    logic [31:0] host_data = '0, mem_din, redirect_addr;
    logic        fetch_stall_in = 1'b0, mem_we, stall_fetch, redirect, running;
    logic [10:0] load_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rdy, we;
        logic [9:0]  addr;
        logic [31:0] din;
        logic        stall, redir, run;
        logic [10:0] cnt;
    } exp_t;

    exp_t sb[$];

    imem_load_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data), .host_last(host_last),
        .fetch_stall_in(fetch_stall_in), .fetch_addr(fetch_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .stall_fetch(stall_fetch), .redirect(redirect),
        .redirect_addr(redirect_addr), .running(running),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".host_ready"},  host_ready,    e.rdy);
        chk({tag, ".mem_we"},      mem_we,        e.we);
        chk({tag, ".mem_addr"},    mem_addr,      e.addr);
        chk({tag, ".mem_din"},     mem_din,       e.din);
        chk({tag, ".stall_fetch"}, stall_fetch,   e.stall);
        chk({tag, ".redirect"},    redirect,      e.redir);
        chk({tag, ".redir_addr"},  redirect_addr, 64'h0);
        chk({tag, ".running"},     running,       e.run);
        chk({tag, ".load_count"},  load_count,    e.cnt);
    endtask

    task automatic drive(input logic hv, input logic [9:0] ha, input logic [31:0] hd,
                         input logic hl, input logic fs, input logic [9:0] fa);
        host_valid = hv; host_addr = ha; host_data = hd; host_last = hl;
        fetch_stall_in = fs; fetch_addr = fa;
    endtask

    // One clock cycle: drive just after the rising edge, check on the falling edge.
    task automatic step(input string tag,
                        input logic hv, input logic [9:0] ha, input logic [31:0] hd,
                        input logic hl, input logic fs, input logic [9:0] fa,
                        input logic rdy, input logic we, input logic [9:0] ea,
                        input logic st, input logic rd, input logic rn, input logic [10:0] cnt);
        exp_t e;
        drive(hv, ha, hd, hl, fs, fa);
        e.rdy = rdy; e.we = we; e.addr = ea; e.din = hd;
        e.stall = st; e.redir = rd; e.run = rn; e.cnt = cnt;
        sb.push_back(e);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check outputs settle without a clock, release.
    task automatic do_reset(input string tag);
        exp_t e;
        drive(1'b1, 10'h007, 32'h1234_5678, 1'b0, 1'b0, 10'h050);
        rst = 1'b0;
        #1;
        e.rdy = 1'b1; e.we = 1'b1; e.addr = 10'h007; e.din = 32'h1234_5678;
        e.stall = 1'b1; e.redir = 1'b0; e.run = 1'b0; e.cnt = 11'd0;
        sb.push_back(e);
        compare(tag);
        drive(1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h050);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset("reset0");

        // Contiguous boot of four words, then flush and run.
        for (int k = 0; k < 4; k++)
            step("boot4", 1'b1, 10'(k), 32'hA0 + 32'(k), k == 3, 1'b0, 10'h055,
                 1'b1, 1'b1, 10'(k), 1'b1, 1'b0, 1'b0, 11'(k));
        step("flush1", 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h000,
             1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd4);
        step("run1",   1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h001,
             1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 1'b1, 11'd4);

        // Mid-run reset, then boot with gaps and a held-off flush.
        do_reset("reset_run");
        step("gap1", 1'b1, 10'h010, 32'hB0, 1'b0, 1'b0, 10'h020, 1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 1'b0, 11'd0);
        step("gap2", 1'b0, 10'h011, 32'hB1, 1'b1, 1'b0, 10'h020, 1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 1'b0, 11'd1);
        step("gap3", 1'b1, 10'h011, 32'hB1, 1'b0, 1'b0, 10'h020, 1'b1, 1'b1, 10'h011, 1'b1, 1'b0, 1'b0, 11'd1);
        step("gap4", 1'b1, 10'h012, 32'hB2, 1'b0, 1'b0, 10'h020, 1'b1, 1'b1, 10'h012, 1'b1, 1'b0, 1'b0, 11'd2);
        step("gap5", 1'b0, 10'h013, 32'hB3, 1'b0, 1'b0, 10'h020, 1'b1, 1'b0, 10'h013, 1'b1, 1'b0, 1'b0, 11'd3);
        step("gap6", 1'b1, 10'h013, 32'hB3, 1'b1, 1'b0, 10'h020, 1'b1, 1'b1, 10'h013, 1'b1, 1'b0, 1'b0, 11'd3);
        for (int k = 0; k < 3; k++)
            step("flush_stall", 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, 10'h030,
                 1'b0, 1'b0, 10'h030, 1'b0, 1'b1, 1'b0, 11'd4);
        step("flush_exit", 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h000,
             1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd4);
        step("run_enter", 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h001,
             1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 1'b1, 11'd4);

        // Patch write on a fetch-stall cycle; host_last is ignored in run.
        step("patch_stall", 1'b1, 10'h3FF, 32'hDEADBEEF, 1'b1, 1'b1, 10'h002,
             1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b1, 11'd4);

        // Held request with fetch running: four refusals, then a forced grant.
        for (int k = 0; k < 4; k++)
            step("refuse", 1'b1, 10'h123, 32'h5555AAAA, 1'b0, 1'b0, 10'h040,
                 1'b0, 1'b0, 10'h040, 1'b0, 1'b0, 1'b1, 11'd4);
        step("forced", 1'b1, 10'h123, 32'h5555AAAA, 1'b0, 1'b0, 10'h040,
             1'b1, 1'b1, 10'h123, 1'b1, 1'b0, 1'b1, 11'd4);
        step("after_forced", 1'b1, 10'h124, 32'h5555AAAB, 1'b0, 1'b0, 10'h041,
             1'b0, 1'b0, 10'h041, 1'b0, 1'b0, 1'b1, 11'd4);
        // Dropping host_valid clears the refusal count.
        step("idle_clear", 1'b0, 10'h124, 32'h5555AAAB, 1'b0, 1'b0, 10'h042,
             1'b0, 1'b0, 10'h042, 1'b0, 1'b0, 1'b1, 11'd4);
        for (int k = 0; k < 4; k++)
            step("refuse2", 1'b1, 10'h124, 32'h5555AAAB, 1'b0, 1'b0, 10'h043,
                 1'b0, 1'b0, 10'h043, 1'b0, 1'b0, 1'b1, 11'd4);
        step("forced2", 1'b1, 10'h124, 32'h5555AAAB, 1'b0, 1'b0, 10'h043,
             1'b1, 1'b1, 10'h124, 1'b1, 1'b0, 1'b1, 11'd4);

        // Reset after two boot words, then a fresh three-word load.
        do_reset("reset_run2");
        step("pre1", 1'b1, 10'h000, 32'hC0, 1'b0, 1'b0, 10'h060, 1'b1, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 11'd0);
        step("pre2", 1'b1, 10'h001, 32'hC1, 1'b0, 1'b0, 10'h060, 1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 1'b0, 11'd1);
        do_reset("reset_boot");
        for (int k = 0; k < 3; k++)
            step("reload", 1'b1, 10'(k), 32'hD0 + 32'(k), k == 2, 1'b0, 10'h060,
                 1'b1, 1'b1, 10'(k), 1'b1, 1'b0, 1'b0, 11'(k));
        step("reflush", 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h000,
             1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd3);
        step("rerun", 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h001,
             1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 1'b1, 11'd3);

        // Counter saturation at 2^ADDR_W across an oversized boot.
        do_reset("reset_sat");
        for (int k = 0; k < 1027; k++)
            step("sat", 1'b1, 10'(k), 32'(k), 1'b0, 1'b0, 10'h070,
                 1'b1, 1'b1, 10'(k), 1'b1, 1'b0, 1'b0, (k > 1024) ? 11'd1024 : 11'(k));
        step("sat_last", 1'b1, 10'h005, 32'h5, 1'b1, 1'b0, 10'h070,
             1'b1, 1'b1, 10'h005, 1'b1, 1'b0, 1'b0, 11'd1024);
        step("sat_flush", 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h000,
             1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
